// File: rtl/majority_pkg.sv
// majority_pkg: shared types and the bitwise popcount-majority helper for the N-way voter.
package majority_pkg;

    typedef enum logic [1:0] {HEALTHY, SUSPECT, FAULTY} chan_state_t;

    function automatic logic maj_bit(input logic [15:0] vec, input int limit);
        int ones;
        ones = 0;
        for (int i = 0; i < 16; i++) ones += int'(vec[i]);
        return ones > limit;
    endfunction

endpackage

// File: rtl/majority_chan_monitor.sv
// majority_chan_monitor: per-channel saturating mismatch counter and consecutive-disagreement fault FSM.
module majority_chan_monitor
    import majority_pkg::*;
#(
    parameter int CNT_W    = 8,
    parameter int FAULT_TH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sample_valid,
    input  logic             disagree,
    input  logic             clr,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             fault
);
    localparam logic [7:0] TH = 8'(FAULT_TH);

    chan_state_t state;
    logic [7:0]  run;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            state        <= HEALTHY;
            run          <= '0;
            mismatch_cnt <= '0;
            fault        <= 1'b0;
        end else if (sample_valid) begin
            if (disagree && mismatch_cnt != '1) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            case (state)
                HEALTHY: if (disagree) begin
                    run   <= 8'd1;
                    state <= TH == 8'd1 ? FAULTY : SUSPECT;
                    fault <= TH == 8'd1;
                end
                SUSPECT: begin
                    run   <= disagree ? run + 8'd1 : 8'd0;
                    state <= !disagree ? HEALTHY : run + 8'd1 == TH ? FAULTY : SUSPECT;
                    fault <= disagree && run + 8'd1 == TH;
                end
                // Sticky: only clr or rst leaves FAULTY, and the run is already saturated here.
                default: fault <= 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/majority_voter_n.sv
// majority_voter_n: bitwise majority vote over N_IN redundant channels with per-channel disagreement stats.
module majority_voter_n
    import majority_pkg::*;
#(
    parameter int N_IN     = 3,
    parameter int DATA_W   = 8,
    parameter int CNT_W    = 8,
    parameter int FAULT_TH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    input  logic [N_IN*DATA_W-1:0] in_data,
    input  logic                   clr_stats,
    output logic                   out_valid,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_unanimous,
    output logic [N_IN*CNT_W-1:0]  mismatch_cnt,
    output logic [N_IN-1:0]        fault
);
    localparam int MAJ_LIMIT = N_IN / 2;

    logic [DATA_W-1:0] maj;
    logic [N_IN-1:0]   dis;

    for (genvar b = 0; b < DATA_W; b++) begin : g_bit
        logic [15:0] col;
        always_comb begin
            col = '0;
            for (int i = 0; i < N_IN; i++) col[i] = in_data[i*DATA_W+b];
        end
        assign maj[b] = maj_bit(col, MAJ_LIMIT);
    end

    for (genvar c = 0; c < N_IN; c++) begin : g_chan
        assign dis[c] = in_data[c*DATA_W +: DATA_W] != maj;
        majority_chan_monitor #(.CNT_W(CNT_W), .FAULT_TH(FAULT_TH)) u_mon (
            .clk          (clk),
            .rst          (rst),
            .sample_valid (in_valid),
            .disagree     (dis[c]),
            .clr          (clr_stats),
            .mismatch_cnt (mismatch_cnt[c*CNT_W +: CNT_W]),
            .fault        (fault[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid     <= 1'b0;
            out_data      <= '0;
            out_unanimous <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data      <= maj;
                out_unanimous <= ~|dis;
            end
        end
    end

endmodule

// File: tb/tb_majority_voter_n.sv
// tb_majority_voter_n: scoreboard bench for the 3-channel voter with small counters and FAULT_TH=3.
module tb_majority_voter_n;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [23:0] in_data = '0;
    logic        clr_stats = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic        out_unanimous;
    logic [11:0] mismatch_cnt;
    logic [2:0]  fault;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       unan;
    } exp_t;
    exp_t sb[$];

    majority_voter_n #(.N_IN(3), .DATA_W(8), .CNT_W(4), .FAULT_TH(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .clr_stats     (clr_stats),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_unanimous (out_unanimous),
        .mismatch_cnt  (mismatch_cnt),
        .fault         (fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_unanimous", 32'(out_unanimous), 32'(e.unan));
            end
        end
    end

    task automatic send(input logic [7:0] c0, input logic [7:0] c1, input logic [7:0] c2,
                        input logic clr = 1'b0);
        exp_t e;
        @(negedge clk);
        in_valid  = 1'b1;
        in_data   = {c2, c1, c0};
        clr_stats = clr;
        e.data = (c0 & c1) | (c0 & c2) | (c1 & c2);
        e.unan = (c0 == c1) && (c1 == c2);
        sb.push_back(e);
    endtask

    task automatic settle(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            in_valid  = 1'b0;
            clr_stats = 1'b0;
        end
    endtask

    task automatic clear();
        @(negedge clk);
        in_valid  = 1'b0;
        clr_stats = 1'b1;
        settle();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_cnt", 32'(mismatch_cnt), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        rst = 1'b0;

        send(8'hA5, 8'hA5, 8'hA5);
        settle();
        check("unan_cnt", 32'(mismatch_cnt), 32'h000);
        check("unan_fault", 32'(fault), 32'd0);

        send(8'hF0, 8'hCC, 8'hAA);
        settle();
        check("split_cnt", 32'(mismatch_cnt), 32'h111);
        check("split_fault", 32'(fault), 32'd0);

        clear();
        check("clear_cnt", 32'(mismatch_cnt), 32'h000);
        send(8'h3C, 8'h3C, 8'h00);
        send(8'h3C, 8'h3C, 8'h00);
        settle(2);
        check("run2_fault", 32'(fault), 32'b000);
        send(8'h3C, 8'h3C, 8'h00);
        settle();
        check("run3_fault", 32'(fault), 32'b100);
        send(8'h3C, 8'h3C, 8'h3C);
        settle();
        check("sticky_fault", 32'(fault), 32'b100);
        check("sticky_cnt", 32'(mismatch_cnt), 32'h300);

        clear();
        send(8'h3C, 8'h3C, 8'h00);
        send(8'h3C, 8'h3C, 8'h00);
        send(8'h3C, 8'h3C, 8'h3C);
        send(8'h3C, 8'h3C, 8'h00);
        send(8'h3C, 8'h3C, 8'h00);
        settle();
        check("ddadd_fault", 32'(fault), 32'b000);
        check("ddadd_cnt", 32'(mismatch_cnt), 32'h400);

        clear();
        for (int i = 0; i < 15; i++) send(8'h55, 8'hAA, 8'h55);
        settle();
        check("sat15_cnt", 32'(mismatch_cnt), 32'h0F0);
        for (int i = 0; i < 5; i++) send(8'h55, 8'hAA, 8'h55);
        settle();
        check("sat20_cnt", 32'(mismatch_cnt), 32'h0F0);
        check("sat20_fault", 32'(fault), 32'b010);

        send(8'h11, 8'h22, 8'h11, 1'b1);
        settle();
        check("clr_win_cnt", 32'(mismatch_cnt), 32'h000);
        check("clr_win_fault", 32'(fault), 32'd0);

        send(8'h77, 8'h77, 8'h76);
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = {8'h00, 8'h99, 8'h99};
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_cnt", 32'(mismatch_cnt), 32'h000);
        check("midrst_fault", 32'(fault), 32'd0);
        rst      = 1'b0;
        in_valid = 1'b0;
        settle(3);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/majority_voter_n.md
Name: majority_voter_n

Overview:
- Parametrised successor to the 3-input single-bit majority gate.
- Votes bitwise across N_IN redundant data channels of DATA_W bits and produces one registered output word.
- Tracks disagreement per channel: a saturating mismatch count and a consecutive-disagreement fault flag.
- Sits behind redundant (TMR/NMR) sources ahead of downstream consumers; statistics are exported for status logging.

Parameters:
- N_IN, 3, number of voted channels; odd, 3..15.
- DATA_W, 8, width of each channel word, 1..64.
- CNT_W, 8, width of each per-channel mismatch counter.
- FAULT_TH, 4, consecutive disagreeing samples that mark a channel faulty; 1..255.

Ports:
- clk  in  1  single clock; all logic updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_data holds a sample to vote this cycle.
- in_data  in  N_IN*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- clr_stats  in  1  clears counters, run lengths and fault flags.
- out_valid  out  1  out_data/out_unanimous valid; one-cycle pulse per sample.
- out_data  out  DATA_W  voted word.
- out_unanimous  out  1  all channels were identical for this sample.
- mismatch_cnt  out  N_IN*CNT_W  per-channel saturating disagreement count, same packing as in_data.
- fault  out  N_IN  per-channel sticky fault flag.

Behaviour:
- Reset: on any edge with rst=1, out_valid=0, out_data=0, out_unanimous=0, all mismatch_cnt=0, all run counters=0, fault=0. in_valid and clr_stats are ignored while rst=1. Reset mid-stream drops the in-flight sample: out_valid is 0 the next cycle.
- Vote: bit b of the majority word is 1 iff the count of channels with bit b = 1 exceeds N_IN/2 (integer division). N_IN is odd, so ties cannot occur.
- Latency: a sample accepted with in_valid=1 at edge t produces out_valid=1, out_data and out_unanimous after edge t, held for exactly one cycle.
- Back-to-back: valid samples are accepted every cycle. There is no backpressure.
- Idle: with in_valid=0, out_valid=0 next cycle. out_data and out_unanimous hold their last values. Statistics are unchanged.
- Disagreement: channel i disagrees when its slice != the majority word (whole-word compare).
- out_unanimous=1 iff no channel disagrees.
- Faulty channels still take part in the vote; the voter never excludes a channel.
- mismatch_cnt[i] increments on every valid sample where channel i disagrees, and saturates at 2^CNT_W-1 (no wrap).
- Per-channel state machine, driven by a run counter that saturates at FAULT_TH:
  - HEALTHY (run=0): disagree -> run=1; go to FAULTY if FAULT_TH=1, else SUSPECT.
  - SUSPECT: disagree -> run+1; reaching FAULT_TH -> FAULTY. Agree -> run=0, HEALTHY.
  - FAULTY: fault[i]=1. Agreement does not leave this state; only clr_stats or rst does. Counting continues.
  - Cycles with in_valid=0 do not advance or clear the run.
- Statistics timing: mismatch_cnt and fault are registered. They reflect all samples accepted up to and including the previous edge, so they update in the same cycle out_valid rises.
- clr_stats=1 at an edge: all mismatch_cnt, run counters and fault go to 0. Clear wins over a coincident valid sample: that sample is still voted and output, but contributes nothing to the statistics.

Decomposition:
- Package majority_pkg:
  - function maj_bit(vector) returning the popcount-majority bit;
  - localparam MAJ_LIMIT = N_IN/2, computed inside the module;
  - enum chan_state_t {HEALTHY, SUSPECT, FAULTY}.
- Sub-module majority_chan_monitor, one instance per channel via generate:
  - inputs: clk, rst, sample_valid, disagree, clr;
  - outputs: mismatch_cnt, fault;
  - contains the run counter and the state machine.
- The top level holds the vote, the output register and the unanimity flag.

Test Plan (N_IN=3, DATA_W=8, CNT_W=4, FAULT_TH=3):
- Reset, then one sample {A5,A5,A5} -> next cycle out_valid=1, out_data=A5, out_unanimous=1, mismatch_cnt all 0, fault=000.
- One sample ch0=F0, ch1=CC, ch2=AA -> out_data=E8, out_unanimous=0, mismatch_cnt={1,1,1}.
- ch2=00, ch0=ch1=3C, three valid samples with 2 idle cycles between the 2nd and 3rd -> fault=100 after the 3rd output edge. A following agreeing sample keeps fault[2]=1; mismatch_cnt[2]=3.
- ch2 pattern D,D,A,D,D (D=disagree, A=agree) -> fault[2] stays 0, because the agreeing sample resets the run.
- 20 consecutive samples with only ch1 disagreeing -> mismatch_cnt[1]=F (saturated), fault=010.
- clr_stats together with a disagreeing valid sample -> out_data voted correctly next cycle; mismatch_cnt all 0, fault=000.
- rst asserted with in_valid=1 mid-stream -> next cycle out_valid=0, out_data=00, all statistics 0.
